clk_edge_sync: RTL and testbench
================================

# clk_edge_sync

Recovers a slow divided clock back into the fast `inputClk` domain as single-cycle tick strobes, so downstream logic runs on `inputClk` with clock enables instead of on a derived clock net. It synchronizes the slow clock and edge-detects it. It also measures the slow-clock period in `inputClk` cycles and asserts `locked` once that period is stable. It sits between a clock-divider chain output, or any slow external clock, and enable-driven logic.

## Interface
- `SYNC_STAGES`, 2: synchronizer flops on `slowClk`; legal range 2–4.
- `CNT_W`, 24: width of the period counter and of `period`.
- `LOCK_COUNT`, 4: consecutive equal periods required to assert `locked`; legal range 1–15.

- `inputClk` in 1: the only clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `slowClk` in 1: slow clock; asynchronous to `inputClk`; each high and low phase is at least 2 `inputClk` cycles.
- `tick` out 1: one-cycle pulse per synchronized `slowClk` rising edge.
- `tickFall` out 1: one-cycle pulse per synchronized `slowClk` falling edge.
- `period` out CNT_W: `inputClk` cycles between the last two ticks.
- `periodValid` out 1: `period` holds a real measurement.
- `locked` out 1: the period has been stable for `LOCK_COUNT` matches.
- `overflow` out 1: sticky flag; the period counter saturated.

## Operation
- **Synchronizer:**
  - Chain `s[0..SYNC_STAGES-1]` feeds `s[SYNC_STAGES-1]` into delay register `d`.
  - Rising edge = `s[last] & ~d`; falling edge = `~s[last] & d`.
  - Both `tick` and `tickFall` are registered.
- **Counter `cnt`** (CNT_W bits):
  - Increments by 1 each cycle and saturates at 2^CNT_W−1.
  - On a rising-edge cycle it loads 1.
- **State `armed`:** clear after reset. The first rising edge sets `armed` and loads `cnt`, with no capture.
- **Capture** (rising edge while armed and `cnt` not saturated):
  - `period` <= `cnt`, `periodValid` <= 1.
  - If the new value equals the previous `period`, `match` increments, saturating at `LOCK_COUNT`. Otherwise `match` <= 0.
- **`locked`:** equals (`match` == `LOCK_COUNT`), registered.
- **Saturation** (`cnt` reaches all-ones, with or without a coincident edge):
  - `overflow` <= 1 (sticky until reset); `periodValid` <= 0; `match` <= 0; `locked` <= 0.
  - `period` holds its value.
  - The next rising edge reloads `cnt` but does not capture. Measurement resumes at the following edge.
- **Reset values:** every output 0; `cnt`, `match`, `armed` and all sync/delay flops 0.

## Timing
- A `slowClk` level first sampled at `inputClk` edge k appears on `tick`/`tickFall` during the cycle after edge k+SYNC_STAGES. Latency is SYNC_STAGES+1 edges, and is identical for rising and falling edges.
- `tick` is exactly 1 cycle wide.
- Ticks N cycles apart give `period` = N.
- `period`, `periodValid` and `locked` update in the same cycle `tick` is high.
- On a mismatching capture, `locked` drops in the same cycle as `tick`.
- A ±1-cycle synchronizer jitter counts as a mismatch (exact compare).
- Asserting `reset` clears all outputs immediately, with no clock needed. After release, the first tick only re-arms.
- A rising-edge cycle coincident with saturation behaves as a saturation, with no capture.

## Configuration
- Macro `CLK_EDGE_SYNC_FALL_EN`.
  - Defined: falling-edge detection and the `tickFall` register are built.
  - Undefined: `tickFall` is tied to 0 and no falling-edge logic exists.
  - The port is present in both builds.

## Test plan
1. **Reset:** hold `reset` with `slowClk` toggling → all outputs 0 throughout.
2. **Steady clock:** `slowClk` = 8-cycle square wave (4 high/4 low) →
   - `tick` one cycle wide every 8 cycles, latency 3 with defaults.
   - First tick: `periodValid`=0.
   - Second tick: `period`=8, `periodValid`=1.
   - `locked`=1 from the 6th tick (4 matches).
3. **Period change:** after lock, switch to a 12-cycle period → at the first 12-cycle tick, `period`=12 and `locked`=0. `locked` re-asserts 4 ticks later.
4. **Stopped clock:** `CNT_W`=4, hold `slowClk` low after lock → 15 cycles after the last tick, `overflow`=1, `periodValid`=0, `locked`=0. Restarting the clock gives no capture on the first tick and `period`=8 on the second. `overflow` stays 1 until reset.
5. **Async reset mid-run:** pulse `reset` between two `inputClk` edges while locked → outputs 0 before the next edge. After release, the first tick gives `periodValid`=0.
6. **Macro check:** with `CLK_EDGE_SYNC_FALL_EN`, `tickFall` pulses 3 cycles after each falling edge and 4 cycles after `tick` for a 4/4 wave. Without the macro, `tickFall` stays 0.

Source files
------------

// File: rtl/clk_edge_sync.sv
// clk_edge_sync: turns a slow clock into inputClk-domain tick strobes and measures its period.
// Define CLK_EDGE_SYNC_FALL_EN to build the falling-edge tickFall strobe.
module clk_edge_sync #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 24,
    parameter int LOCK_COUNT  = 4
) (
    input  logic             inputClk,
    input  logic             reset,
    input  logic             slowClk,
    output logic             tick,
    output logic             tickFall,
    output logic [CNT_W-1:0] period,
    output logic             periodValid,
    output logic             locked,
    output logic             overflow
);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [3:0]       LOCK_MAX = 4'(LOCK_COUNT);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   dly_q;
    logic                   rise;
    logic                   tick_q;

    always_ff @(posedge inputClk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            dly_q  <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], slowClk};
            dly_q  <= sync_q[SYNC_STAGES-1];
            tick_q <= rise;
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~dly_q;
    assign tick = tick_q;

`ifdef CLK_EDGE_SYNC_FALL_EN
    logic fall;
    logic tick_fall_q;

    assign fall = ~sync_q[SYNC_STAGES-1] & dly_q;

    always_ff @(posedge inputClk or posedge reset) begin
        if (reset) begin
            tick_fall_q <= 1'b0;
        end else begin
            tick_fall_q <= fall;
        end
    end

    assign tickFall = tick_fall_q;
`else
    assign tickFall = 1'b0;
`endif

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [3:0]       match_q, match_d;
    logic             armed_q, armed_d;
    logic             valid_q, valid_d;
    logic             locked_q, locked_d;
    logic             ovf_q, ovf_d;
    logic             sat;
    logic             capture;

    assign sat     = (cnt_q == CNT_MAX);
    assign capture = rise & armed_q & ~sat;

    always_comb begin
        cnt_d    = cnt_q;
        armed_d  = armed_q;
        period_d = period_q;
        valid_d  = valid_q;
        match_d  = match_q;
        ovf_d    = ovf_q;

        if (rise) begin
            cnt_d = CNT_ONE;
        end else if (!sat) begin
            cnt_d = cnt_q + CNT_ONE;
        end

        // A saturated count is not a period; the next edge only re-arms.
        if (rise) begin
            armed_d = 1'b1;
        end else if (sat) begin
            armed_d = 1'b0;
        end

        if (sat) begin
            ovf_d   = 1'b1;
            valid_d = 1'b0;
            match_d = 4'd0;
        end else if (capture) begin
            period_d = cnt_q;
            valid_d  = 1'b1;
            if (cnt_q == period_q) begin
                if (match_q != LOCK_MAX) begin
                    match_d = match_q + 4'd1;
                end
            end else begin
                match_d = 4'd0;
            end
        end

        locked_d = (match_d == LOCK_MAX);
    end

    always_ff @(posedge inputClk or posedge reset) begin
        if (reset) begin
            cnt_q    <= '0;
            armed_q  <= 1'b0;
            period_q <= '0;
            valid_q  <= 1'b0;
            match_q  <= 4'd0;
            locked_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            armed_q  <= armed_d;
            period_q <= period_d;
            valid_q  <= valid_d;
            match_q  <= match_d;
            locked_q <= locked_d;
            ovf_q    <= ovf_d;
        end
    end

    assign period      = period_q;
    assign periodValid = valid_q;
    assign locked      = locked_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_clk_edge_sync.sv
// Directed bench for clk_edge_sync: default instance plus a CNT_W=4 instance
// for the saturation scenario; both share the same stimulus.
module tb_clk_edge_sync;

    logic        inputClk = 1'b0;
    logic        reset    = 1'b1;
    logic        slowClk  = 1'b0;

    logic        tick, tickFall, periodValid, locked, overflow;
    logic [23:0] period;
    logic        tick4, tickFall4, periodValid4, locked4, overflow4;
    logic [3:0]  period4;

    int checks   = 0;
    int failures = 0;

    clk_edge_sync dut (
        .inputClk   (inputClk),
        .reset      (reset),
        .slowClk    (slowClk),
        .tick       (tick),
        .tickFall   (tickFall),
        .period     (period),
        .periodValid(periodValid),
        .locked     (locked),
        .overflow   (overflow)
    );

    clk_edge_sync #(.CNT_W(4)) dut4 (
        .inputClk   (inputClk),
        .reset      (reset),
        .slowClk    (slowClk),
        .tick       (tick4),
        .tickFall   (tickFall4),
        .period     (period4),
        .periodValid(periodValid4),
        .locked     (locked4),
        .overflow   (overflow4)
    );

    always #5 inputClk = ~inputClk;

    task automatic step();
        @(posedge inputClk);
        #1;
    endtask

    task automatic apply_reset();
        reset   = 1'b1;
        slowClk = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        repeat (2) step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 24; i++) begin
            slowClk = ((i % 6) < 3);
            step();
            checks++;
            if ({tick, tickFall, periodValid, locked, overflow} !== 5'b0 ||
                period !== 24'd0) begin
                failures++;
                $display("FAIL reset_hold n=%0d tick=%b fall=%b pv=%b lk=%b ov=%b per=%0d exp all 0",
                         i, tick, tickFall, periodValid, locked, overflow, period);
            end
            checks++;
            if ({tick4, tickFall4, periodValid4, locked4, overflow4} !== 5'b0 ||
                period4 !== 4'd0) begin
                failures++;
                $display("FAIL reset_hold4 n=%0d got nonzero outputs exp all 0", i);
            end
        end
        slowClk = 1'b0;
        step();
        reset = 1'b0;
        repeat (2) step();
    endtask

    task automatic test_steady();
        int   nt;
        logic et, ev, el;
        apply_reset();
        nt = 0;
        for (int i = 0; i < 64; i++) begin
            slowClk = ((i % 8) < 4);
            step();
            et = ((i + 1) % 8 == 3);
            checks++;
            if (tick !== et) begin
                failures++;
                $display("FAIL steady_tick n=%0d got=%b exp=%b", i + 1, tick, et);
            end
            if (et) begin
                nt++;
                ev = (nt >= 2);
                el = (nt >= 6);
                checks++;
                if (periodValid !== ev) begin
                    failures++;
                    $display("FAIL steady_valid tick=%0d got=%b exp=%b", nt, periodValid, ev);
                end
                if (nt >= 2) begin
                    checks++;
                    if (period !== 24'd8) begin
                        failures++;
                        $display("FAIL steady_period tick=%0d got=%0d exp=8", nt, period);
                    end
                end
                checks++;
                if (locked !== el) begin
                    failures++;
                    $display("FAIL steady_locked tick=%0d got=%b exp=%b", nt, locked, el);
                end
            end
        end
    endtask

    task automatic test_period_change();
        int          nt;
        logic        et, el;
        logic [23:0] ep;
        nt = 0;
        for (int i = 0; i < 72; i++) begin
            slowClk = ((i % 12) < 6);
            step();
            et = ((i + 1) % 12 == 3);
            checks++;
            if (tick !== et) begin
                failures++;
                $display("FAIL change_tick n=%0d got=%b exp=%b", i + 1, tick, et);
            end
            if (et) begin
                nt++;
                ep = (nt == 1) ? 24'd8 : 24'd12;
                el = (nt == 1) || (nt >= 6);
                checks++;
                if (period !== ep) begin
                    failures++;
                    $display("FAIL change_period tick=%0d got=%0d exp=%0d", nt, period, ep);
                end
                checks++;
                if (locked !== el) begin
                    failures++;
                    $display("FAIL change_locked tick=%0d got=%b exp=%b", nt, locked, el);
                end
            end
        end
    endtask

    task automatic test_stopped_clock();
        apply_reset();
        for (int i = 0; i < 56; i++) begin
            slowClk = ((i % 8) < 4);
            step();
        end
        slowClk = 1'b0;
        for (int n = 57; n <= 80; n++) begin
            step();
            if (n == 65) begin
                checks++;
                if (overflow4 !== 1'b0 || locked4 !== 1'b1 || periodValid4 !== 1'b1) begin
                    failures++;
                    $display("FAIL stop_before ov=%b lk=%b pv=%b exp ov=0 lk=1 pv=1",
                             overflow4, locked4, periodValid4);
                end
            end
            if (n == 66) begin
                checks++;
                if (overflow4 !== 1'b1 || locked4 !== 1'b0 || periodValid4 !== 1'b0) begin
                    failures++;
                    $display("FAIL stop_sat ov=%b lk=%b pv=%b exp ov=1 lk=0 pv=0",
                             overflow4, locked4, periodValid4);
                end
                checks++;
                if (period4 !== 4'd8) begin
                    failures++;
                    $display("FAIL stop_hold_period got=%0d exp=8", period4);
                end
                checks++;
                if (overflow !== 1'b0 || locked !== 1'b1) begin
                    failures++;
                    $display("FAIL stop_wide_cnt ov=%b lk=%b exp ov=0 lk=1", overflow, locked);
                end
            end
        end
        for (int i = 0; i < 24; i++) begin
            slowClk = ((i % 8) < 4);
            step();
            if (i + 1 == 3) begin
                checks++;
                if (tick4 !== 1'b1 || periodValid4 !== 1'b0 || overflow4 !== 1'b1) begin
                    failures++;
                    $display("FAIL restart_first tick=%b pv=%b ov=%b exp tick=1 pv=0 ov=1",
                             tick4, periodValid4, overflow4);
                end
            end
            if (i + 1 == 11) begin
                checks++;
                if (tick4 !== 1'b1 || periodValid4 !== 1'b1 || period4 !== 4'd8) begin
                    failures++;
                    $display("FAIL restart_second tick=%b pv=%b per=%0d exp tick=1 pv=1 per=8",
                             tick4, periodValid4, period4);
                end
                checks++;
                if (overflow4 !== 1'b1 || locked4 !== 1'b0) begin
                    failures++;
                    $display("FAIL restart_sticky ov=%b lk=%b exp ov=1 lk=0", overflow4, locked4);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        for (int i = 0; i < 56; i++) begin
            slowClk = ((i % 8) < 4);
            step();
        end
        checks++;
        if (locked !== 1'b1 || periodValid !== 1'b1) begin
            failures++;
            $display("FAIL areset_pre lk=%b pv=%b exp lk=1 pv=1", locked, periodValid);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({tick, periodValid, locked, overflow} !== 4'b0 || period !== 24'd0) begin
            failures++;
            $display("FAIL areset_clear tick=%b pv=%b lk=%b ov=%b per=%0d exp all 0",
                     tick, periodValid, locked, overflow, period);
        end
        checks++;
        if (locked4 !== 1'b0 || period4 !== 4'd0) begin
            failures++;
            $display("FAIL areset_clear4 lk=%b per=%0d exp lk=0 per=0", locked4, period4);
        end
        #1;
        reset = 1'b0;
        step();
        for (int i = 0; i < 16; i++) begin
            slowClk = ((i % 8) < 4);
            step();
            if (i + 1 == 3) begin
                checks++;
                if (tick !== 1'b1 || periodValid !== 1'b0) begin
                    failures++;
                    $display("FAIL areset_rearm tick=%b pv=%b exp tick=1 pv=0", tick, periodValid);
                end
            end
            if (i + 1 == 11) begin
                checks++;
                if (tick !== 1'b1 || periodValid !== 1'b1 || period !== 24'd8) begin
                    failures++;
                    $display("FAIL areset_measure tick=%b pv=%b per=%0d exp tick=1 pv=1 per=8",
                             tick, periodValid, period);
                end
            end
        end
    endtask

    task automatic test_fall();
        logic ef;
        apply_reset();
        for (int i = 0; i < 32; i++) begin
            slowClk = ((i % 8) < 4);
            step();
`ifdef CLK_EDGE_SYNC_FALL_EN
            ef = ((i + 1) % 8 == 7);
`else
            ef = 1'b0;
`endif
            checks++;
            if (tickFall !== ef) begin
                failures++;
                $display("FAIL fall_tick n=%0d got=%b exp=%b", i + 1, tickFall, ef);
            end
        end
    endtask

    initial begin
        test_reset();
        test_steady();
        test_period_change();
        test_stopped_clock();
        test_async_reset();
        test_fall();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
